subtractor_32b_serial: RTL and testbench

Digit-serial two's-complement subtractor computing `a - b - b_in` over `w/d` clock cycles, least-significant digit first. It is the inverse-operation companion to the team's 32-bit adder. It serves datapaths that trade latency for area and need a registered result with a start/done handshake. Result outputs hold until the next operation completes.

---
 rtl/subtractor_32b_serial.sv | 124 ++++++++++++
 tb/tb_subtractor_32b_serial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/subtractor_32b_serial.sv
// Digit-serial two's-complement subtractor: diff = a - b - b_in, d bits per cycle,
// least-significant digit first, with a start/busy/done handshake and held results.
module subtractor_32b_serial #(
    parameter int w = 32,
    parameter int d = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    input  logic         b_in,
    output logic [w-1:0] diff,
    output logic         b_out,
    output logic         overflow,
    output logic         busy,
    output logic         done
);

    localparam int n_dig = w / d;
    localparam int cnt_w = (n_dig > 1) ? $clog2(n_dig) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, next_state;

    logic [w-1:0]     a_sh;
    logic [w-1:0]     b_sh;
    logic [w-1:0]     work;
    logic [w-1:0]     work_next;
    logic             br;
    logic             a_sign;
    logic             b_sign;
    logic [cnt_w-1:0] cnt;
    logic [d:0]       dig_full;
    logic             last;
    logic             accept;
    logic             finish;

    // Operands are shifted right each cycle, so digit k always sits in the low d bits.
    always_comb begin
        dig_full  = {1'b0, a_sh[d-1:0]} - {1'b0, b_sh[d-1:0]} - {{d{1'b0}}, br};
        work_next = (work >> d) | (w'(dig_full[d-1:0]) << (w - d));
        last      = (cnt == cnt_w'(n_dig - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples
            // pre-edge values regardless of the order blocks are evaluated in.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that left
        // one unassigned would infer a latch.
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            work     <= '0;
            br       <= 1'b0;
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            cnt      <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                br     <= b_in;
                a_sign <= a[w-1];
                b_sign <= b[w-1];
                work   <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> d;
                b_sh <= b_sh >> d;
                br   <= dig_full[d];
                work <= work_next;
                cnt  <= last ? '0 : cnt + cnt_w'(1);
            end
            // Results are published only on completion and otherwise hold.
            if (finish) begin
                diff     <= work_next;
                b_out    <= dig_full[d];
                overflow <= (a_sign != b_sign) && (work_next[w-1] != a_sign);
            end
        end
    end

endmodule

// File: tb/tb_subtractor_32b_serial.sv
// Scoreboard bench for subtractor_32b_serial: three instances (d = 8, 1, 32) share operand
// inputs; expected results are queued at issue time and checked by a done-driven monitor.
module tb_subtractor_32b_serial;

    typedef struct {
        logic [31:0] diff;
        logic        b_out;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        b_in = 1'b0;
    logic        start_v [3];
    logic [31:0] diff_o  [3];
    logic        b_out_o [3];
    logic        ovf_o   [3];
    logic        busy_o  [3];
    logic        done_o  [3];

    exp_t sb [3][$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    subtractor_32b_serial #(.w(32), .d(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b), .b_in(b_in),
        .diff(diff_o[0]), .b_out(b_out_o[0]), .overflow(ovf_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    subtractor_32b_serial #(.w(32), .d(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b), .b_in(b_in),
        .diff(diff_o[1]), .b_out(b_out_o[1]), .overflow(ovf_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    subtractor_32b_serial #(.w(32), .d(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b), .b_in(b_in),
        .diff(diff_o[2]), .b_out(b_out_o[2]), .overflow(ovf_o[2]),
        .busy(busy_o[2]), .done(done_o[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called at a negedge; drives one start pulse across the next rising edge (E0).
    task automatic issue(input int id, input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, input bit push, input logic [31:0] ed,
                         input logic eb, input logic eo);
        exp_t e;
        int   n;
        n = (id == 0) ? 4 : (id == 1) ? 32 : 1;
        a = av;
        b = bv;
        b_in = bi;
        start_v[id] = 1'b1;
        if (push) begin
            e.diff = ed;
            e.b_out = eb;
            e.ovf = eo;
            e.done_cyc = cyc + 1 + n;
            sb[id].push_back(e);
        end
        @(posedge clk);
        #1;
        start_v[id] = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        b_in = 1'b1;
    endtask

    task automatic drain();
        bit idle;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            idle = 1'b1;
            for (int k = 0; k < 3; k++)
                if (sb[k].size() != 0 || busy_o[k]) idle = 1'b0;
            if (idle) return;
        end
        check("drain_timeout", 64'd1, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (done_o[i]) begin
                    if (sb[i].size() == 0) begin
                        check($sformatf("unexpected_done_dut%0d", i), 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        check($sformatf("diff_dut%0d", i), 64'(diff_o[i]), 64'(e.diff));
                        check($sformatf("b_out_dut%0d", i), 64'(b_out_o[i]), 64'(e.b_out));
                        check($sformatf("overflow_dut%0d", i), 64'(ovf_o[i]), 64'(e.ovf));
                        check($sformatf("latency_dut%0d", i), 64'(cyc), 64'(e.done_cyc));
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_diff", 64'(diff_o[0]), 64'd0);
        check("rst_b_out", 64'(b_out_o[0]), 64'd0);
        check("rst_overflow", 64'(ovf_o[0]), 64'd0);
        check("rst_busy", 64'(busy_o[0]), 64'd0);
        check("rst_done", 64'(done_o[0]), 64'd0);
        rst_n = 1'b1;

        // Basic case, with busy high for exactly four cycles.
        @(negedge clk);
        issue(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("busy_window_%0d", i), 64'(busy_o[0]), (i < 4) ? 64'd1 : 64'd0);
        end
        drain();

        @(negedge clk);
        issue(0, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drain();
        issue(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        drain();
        issue(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
        drain();
        issue(0, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 32'h1234_5677, 1'b0, 1'b0);
        drain();

        // Borrow rippling across digits, on all three digit widths.
        for (int id = 0; id < 3; id++) begin
            issue(id, 32'h0000_0100, 32'h0000_00FF, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
            drain();
        end

        // start while busy must be ignored.
        issue(0, 32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0FFF, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 32'h0000_0000;
        b = 32'h0000_0005;
        b_in = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        drain();

        // Back-to-back: start accepted in the done cycle; old result held meanwhile.
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = done_o[0];
        end
        check("b2b_done_seen", 64'(seen), 64'd1);
        issue(0, 32'd10, 32'd4, 1'b0, 1'b1, 32'd6, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_during_run", 64'(diff_o[0]), 64'hFFFF_FFFF);
        drain();

        // Reset after E2 of an operation: outputs clear at once, no done follows.
        issue(0, 32'd99, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_diff", 64'(diff_o[0]), 64'd0);
        check("abort_busy", 64'(busy_o[0]), 64'd0);
        check("abort_done", 64'(done_o[0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_busy", 64'(busy_o[0]), 64'd0);
        issue(0, 32'd7, 32'd7, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
